card_blit_ctrl: RTL and testbench

//  Command-driven write-side sequencer for the 256x240x3b frame buffer (dual-port mem, port A).

---
 rtl/card_gfx_pkg.sv | 41 ++++
 rtl/card_blit_ctrl_if.sv | 43 ++++
 rtl/card_blit_ctrl_rect_walker.sv | 65 ++++++
 rtl/card_blit_ctrl.sv | 160 ++++++++++++++++
 tb/tb_card_blit_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/card_gfx_pkg.sv
// -----------------------------------------------------------------------------
// card_gfx_pkg
//   Shared geometry, address widths and type definitions for the card
//   blitter: frame-buffer size, card sprite size, sprite ROM layout, the
//   command opcode enum and the blitter state enum.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package card_gfx_pkg;

    localparam int FB_COLS      = 256;
    localparam int FB_ROWS      = 240;
    localparam int FB_WORDS     = FB_COLS * FB_ROWS;   // 61440
    localparam int C_LENGTH     = 16;
    localparam int C_HEIGHT     = 20;
    localparam int NUM_CARDS    = 36;
    localparam int SPRITE_WORDS = C_LENGTH * C_HEIGHT; // 320
    localparam int FB_AW        = 17;
    localparam int ROM_AW       = 14;

    typedef enum logic {
        OP_BLIT  = 1'b0,
        OP_CLEAR = 1'b1
    } blit_op_e;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        BLIT,
        FILL,
        DRAIN,
        DONE
    } blit_state_e;

    // First ROM word of sprite n: n*320 = n*256 + n*64.
    function automatic logic [ROM_AW-1:0] sprite_base(input logic [5:0] card);
        logic [ROM_AW-1:0] c;
        c = {8'b0, card};
        return (c << 8) + (c << 6);
    endfunction

endpackage

// File: rtl/card_blit_ctrl_if.sv
// -----------------------------------------------------------------------------
// card_blit_ctrl_if
//   Bundles the blitter's command handshake, sprite ROM read port,
//   frame-buffer write port and status flags.
//   slave  modport: the blitter (consumes commands / ROM data, drives writes)
//   master modport: the environment (game logic, ROM, frame buffer)
//   Signals:
//     cmd_valid/cmd_ready  command handshake
//     cmd_op/card/x/y/color command fields (sampled on accept)
//     rom_addr/rom_data    sprite ROM, data returns one cycle after address
//     fb_we/fb_addr/fb_data frame-buffer port A write
//     busy/done/err        status (done/err are one-cycle pulses)
// -----------------------------------------------------------------------------
interface card_blit_ctrl_if;
    import card_gfx_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    blit_op_e            cmd_op;
    logic [5:0]          cmd_card;
    logic [7:0]          cmd_x;
    logic [7:0]          cmd_y;
    logic [2:0]          cmd_color;
    logic [ROM_AW-1:0]   rom_addr;
    logic [2:0]          rom_data;
    logic                fb_we;
    logic [FB_AW-1:0]    fb_addr;
    logic [2:0]          fb_data;
    logic                busy;
    logic                done;
    logic                err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_card, cmd_x, cmd_y, cmd_color, rom_data,
        output cmd_ready, rom_addr, fb_we, fb_addr, fb_data, busy, done, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_card, cmd_x, cmd_y, cmd_color, rom_data,
        input  cmd_ready, rom_addr, fb_we, fb_addr, fb_data, busy, done, err
    );

endinterface

// File: rtl/card_blit_ctrl_rect_walker.sv
// -----------------------------------------------------------------------------
// rect_walker
//   Row/column counters that scan a W x H rectangle, column innermost.
//   Ports:
//     clock, reset  system clock, synchronous active-high reset
//     start_i       restart at (row 0, col 0); wins over step_i
//     step_i        advance one pixel; holds once the last pixel is reached
//     col_o, row_o  current pixel
//     last_o        current pixel is (H-1, W-1)
// -----------------------------------------------------------------------------
module rect_walker #(
    parameter int W  = 16,
    parameter int H  = 20,
    parameter int CW = $clog2(W),
    parameter int RW = $clog2(H)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start_i,
    input  logic          step_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          last_o
);

    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          last;

    assign last = (col_q == COL_LAST) && (row_q == ROW_LAST);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start_i) begin
            col_d = '0;
            row_d = '0;
        end else if (step_i && !last) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = last;

endmodule

// File: rtl/card_blit_ctrl.sv
// -----------------------------------------------------------------------------
// card_blit_ctrl
//   Write-side sequencer for the 256x240x3b frame buffer. A BLIT command
//   copies one 16x20 card sprite from the sprite ROM to pixel (x,y), skipping
//   transparent pixels; a CLEAR command fills the whole frame with one colour.
//   Ports:
//     clock   system clock
//     reset   synchronous, active-high; aborts any command in flight
//     bus     card_blit_ctrl_if.slave: command handshake, ROM read port,
//             frame-buffer write port, busy/done/err status
// -----------------------------------------------------------------------------
module card_blit_ctrl
    import card_gfx_pkg::*;
#(
    parameter bit         TRANSP_EN  = 1'b1,
    parameter logic [2:0] TRANSP_KEY = 3'b000
) (
    input  logic             clock,
    input  logic             reset,
    card_blit_ctrl_if.slave  bus
);

    localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(FB_WORDS - 1);

    blit_state_e       state_q, state_d;

    // Command fields, loaded only on accept.
    blit_op_e          op_q;
    logic [5:0]        card_q;
    logic [7:0]        x_q;
    logic [7:0]        y_q;
    logic [2:0]        color_q;

    logic [ROM_AW-1:0] rom_addr_q;
    logic [FB_AW-1:0]  fb_addr_q;
    logic              wr_vld_q;     // a ROM read was issued last cycle

    logic              accept;
    logic              reject;
    logic [8:0]        x_end;
    logic [8:0]        y_end;
    logic              walk_start;
    logic              walk_last;
    logic [3:0]        walk_col;
    logic [4:0]        walk_row;
    logic              fill_last;
    logic [FB_AW-1:0]  blit_addr;
    logic              transparent;

    assign accept = bus.cmd_valid && bus.cmd_ready;

    // Nine-bit sums so x=255 + 16 cannot wrap into a false pass.
    assign x_end  = {1'b0, x_q} + 9'(C_LENGTH);
    assign y_end  = {1'b0, y_q} + 9'(C_HEIGHT);
    assign reject = (card_q >= 6'(NUM_CARDS)) ||
                    (x_end > 9'(FB_COLS)) ||
                    (y_end > 9'(FB_ROWS));

    assign walk_start = (state_q == CHECK) && (op_q == OP_BLIT) && !reject;
    assign fill_last  = (fb_addr_q == FB_LAST);

    // FB_COLS is 256, so y*FB_COLS + x is just {y, x}.
    assign blit_addr   = {1'b0, y_q + 8'(walk_row), x_q + 8'(walk_col)};
    assign transparent = TRANSP_EN && (bus.rom_data == TRANSP_KEY);

    rect_walker #(
        .W (C_LENGTH),
        .H (C_HEIGHT)
    ) u_walker (
        .clock   (clock),
        .reset   (reset),
        .start_i (walk_start),
        .step_i  (state_q == BLIT),
        .col_o   (walk_col),
        .row_o   (walk_row),
        .last_o  (walk_last)
    );

    // Next state and outputs. Strobes are masked by reset so an abort takes
    // effect in the very cycle reset is raised.
    always_comb begin
        state_d       = state_q;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.fb_we     = 1'b0;
        bus.fb_data   = 3'b000;

        unique case (state_q)
            IDLE:  if (accept) state_d = CHECK;
            CHECK: begin
                if (op_q == OP_CLEAR) state_d = FILL;
                else if (reject)      state_d = IDLE;
                else                  state_d = BLIT;
            end
            BLIT:  if (walk_last) state_d = DRAIN;
            FILL:  if (fill_last) state_d = DONE;
            DRAIN: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!reset) begin
            bus.cmd_ready = (state_q == IDLE);
            bus.busy      = (state_q != IDLE);
            bus.done      = (state_q == DONE);
            bus.err       = (state_q == CHECK) && (op_q == OP_BLIT) && reject;
            if (state_q == FILL) begin
                bus.fb_we   = 1'b1;
                bus.fb_data = color_q;
            end else if (wr_vld_q) begin
                bus.fb_we   = !transparent;
                bus.fb_data = bus.rom_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_vld_q   <= 1'b0;
            rom_addr_q <= '0;
            fb_addr_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_vld_q <= (state_q == BLIT);

            // Sprite words are row-major and contiguous, so the read address
            // simply counts up from the sprite base.
            if (walk_start)
                rom_addr_q <= sprite_base(card_q);
            else if ((state_q == BLIT) && !walk_last)
                rom_addr_q <= rom_addr_q + ROM_AW'(1);

            // Write address: the BLIT path registers the address of the pixel
            // being read now, so it lines up with rom_data next cycle.
            if ((state_q == CHECK) && (op_q == OP_CLEAR))
                fb_addr_q <= '0;
            else if ((state_q == FILL) && !fill_last)
                fb_addr_q <= fb_addr_q + FB_AW'(1);
            else if (state_q == BLIT)
                fb_addr_q <= blit_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            op_q    <= bus.cmd_op;
            card_q  <= bus.cmd_card;
            x_q     <= bus.cmd_x;
            y_q     <= bus.cmd_y;
            color_q <= bus.cmd_color;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.fb_addr  = fb_addr_q;

endmodule

// File: tb/tb_card_blit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_card_blit_ctrl
//   Self-checking bench for card_blit_ctrl: sprite ROM model, write/pulse
//   monitor, and a pixel-level reference model of the expected writes.
// -----------------------------------------------------------------------------
module tb_card_blit_ctrl;
    import card_gfx_pkg::*;

    localparam bit         TB_TRANSP_EN = 1'b1;
    localparam logic [2:0] TB_KEY       = 3'b000;
    localparam int         ROM_WORDS    = NUM_CARDS * SPRITE_WORDS;

    typedef struct {
        int c;
        int a;
        int d;
    } wr_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [2:0] rom [0:ROM_WORDS-1];
    wr_t        wq[$];
    wr_t        expq[$];
    int         done_q[$];
    int         err_q[$];

    card_blit_ctrl_if bus();

    card_blit_ctrl #(
        .TRANSP_EN  (TB_TRANSP_EN),
        .TRANSP_KEY (TB_KEY)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous sprite ROM: one cycle read latency.
    always @(posedge clock) bus.rom_data <= rom[int'(bus.rom_addr) % ROM_WORDS];

    // Record every write and every status pulse with its cycle number.
    always @(negedge clock) begin : mon
        wr_t w;
        if (bus.fb_we === 1'b1) begin
            w.c = cyc;
            w.a = int'(bus.fb_addr);
            w.d = int'(bus.fb_data);
            wq.push_back(w);
        end
        if (bus.done === 1'b1) done_q.push_back(cyc);
        if (bus.err === 1'b1)  err_q.push_back(cyc);
    end

    // mode 0: random, 1: index pattern, 2: alternating 000/101, 3: random non-key
    task automatic fill_card(input int card, input int mode);
        for (int i = 0; i < SPRITE_WORDS; i++) begin
            case (mode)
                1:       rom[card*SPRITE_WORDS + i] = 3'(i % 8);
                2:       rom[card*SPRITE_WORDS + i] = (i % 2 == 1) ? 3'b101 : 3'b000;
                3:       rom[card*SPRITE_WORDS + i] = 3'($urandom_range(7, 1));
                default: rom[card*SPRITE_WORDS + i] = 3'($urandom_range(7, 0));
            endcase
        end
    endtask

    // Reference model: pixel p = row*16 + col is read at T+2+p, written at
    // T+3+p to (y+row)*256 + (x+col), unless it carries the transparent key.
    task automatic build_exp(input int card, input int x, input int y, input int t, input int npix);
        wr_t w;
        int  v;
        expq.delete();
        for (int p = 0; p < npix; p++) begin
            v = int'(rom[card*SPRITE_WORDS + p]);
            if (!(TB_TRANSP_EN && v == int'(TB_KEY))) begin
                w.c = t + 3 + p;
                w.a = (y + p / C_LENGTH) * FB_COLS + x + p % C_LENGTH;
                w.d = v;
                expq.push_back(w);
            end
        end
    endtask

    task automatic send_cmd(input blit_op_e op, input int card, input int x, input int y,
                            input int color, output int t);
        int k;
        @(negedge clock);
        bus.cmd_op    = op;
        bus.cmd_card  = 6'(card);
        bus.cmd_x     = 8'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_color = 3'(color);
        bus.cmd_valid = 1'b1;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 50) begin
            @(negedge clock);
            k++;
        end
        n_chk++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, k);
        end
        t = cyc;
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_blit(input string tag, input int card, input int x, input int y);
        int t, k, dc;
        wq.delete(); done_q.delete(); err_q.delete();
        send_cmd(OP_BLIT, card, x, y, 0, t);
        build_exp(card, x, y, t, SPRITE_WORDS);
        @(negedge clock);
        n_chk++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.fb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL %s check-cycle: busy=%b ready=%b we=%b, required 1 0 0",
                     tag, bus.busy, bus.cmd_ready, bus.fb_we);
        end
        @(negedge clock);
        n_chk++;
        if (int'(bus.rom_addr) != card * SPRITE_WORDS) begin
            n_fail++;
            $display("FAIL %s first rom_addr: got %0d required %0d", tag, bus.rom_addr, card*SPRITE_WORDS);
        end
        k = 0;
        while (done_q.size() == 0 && k < 400) begin
            @(negedge clock);
            k++;
        end
        repeat (2) @(negedge clock);
        dc = (done_q.size() > 0) ? done_q[0] : -1;
        n_chk++;
        if (done_q.size() != 1 || dc != t + 323) begin
            n_fail++;
            $display("FAIL %s done: %0d pulses at %0d, required 1 at %0d", tag, done_q.size(), dc, t + 323);
        end
        n_chk++;
        if (err_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s err: got %0d pulses required 0", tag, err_q.size());
        end
        n_chk++;
        if (wq.size() != expq.size()) begin
            n_fail++;
            $display("FAIL %s write count: got %0d required %0d", tag, wq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < wq.size(); i++) begin
            n_chk++;
            if (wq[i].c != expq[i].c || wq[i].a != expq[i].a || wq[i].d != expq[i].d) begin
                n_fail++;
                $display("FAIL %s write %0d: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                         tag, i, wq[i].c, wq[i].a, wq[i].d, expq[i].c, expq[i].a, expq[i].d);
                break;
            end
        end
        n_chk++;
        if (int'(bus.rom_addr) != card * SPRITE_WORDS + SPRITE_WORDS - 1 || bus.busy !== 1'b0 ||
            bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after done: rom_addr=%0d busy=%b ready=%b required %0d 0 1",
                     tag, bus.rom_addr, bus.busy, bus.cmd_ready, card*SPRITE_WORDS + SPRITE_WORDS - 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_chk++;
        if (bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset ready: got %b required 0", bus.cmd_ready);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        n_chk++;
        if (bus.rom_addr !== '0 || bus.fb_we !== 1'b0 || bus.fb_addr !== '0 || bus.fb_data !== 3'b000 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: rom_addr=%0d we=%b fb_addr=%0d fb_data=%0d busy=%b done=%b err=%b required all 0",
                     bus.rom_addr, bus.fb_we, bus.fb_addr, bus.fb_data, bus.busy, bus.done, bus.err);
        end
        n_chk++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle ready: got %b required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_blit_origin();
        fill_card(0, 1);
        run_blit("blit_origin", 0, 0, 0);
    endtask

    task automatic test_blit_corner();
        fill_card(35, 3);
        run_blit("blit_corner", 35, 240, 220);
        n_chk++;
        if (wq.size() == 0 || wq[wq.size()-1].a != FB_WORDS - 1) begin
            n_fail++;
            $display("FAIL blit_corner last addr: got %0d required %0d",
                     (wq.size() > 0) ? wq[wq.size()-1].a : -1, FB_WORDS - 1);
        end
    endtask

    task automatic test_reject();
        int cards [4] = '{0, 36, 0, 63};
        int xs    [4] = '{241, 0, 0, 255};
        int ys    [4] = '{0, 0, 221, 255};
        int t;
        for (int i = 0; i < 4; i++) begin
            wq.delete(); done_q.delete(); err_q.delete();
            send_cmd(OP_BLIT, cards[i], xs[i], ys[i], 0, t);
            @(negedge clock);
            n_chk++;
            if (bus.err !== 1'b1 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL reject %0d at T+1: err=%b busy=%b required 1 1", i, bus.err, bus.busy);
            end
            @(negedge clock);
            n_chk++;
            if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
                n_fail++;
                $display("FAIL reject %0d at T+2: ready=%b busy=%b err=%b required 1 0 0",
                         i, bus.cmd_ready, bus.busy, bus.err);
            end
            repeat (3) @(negedge clock);
            n_chk++;
            if (wq.size() != 0 || err_q.size() != 1 || done_q.size() != 0) begin
                n_fail++;
                $display("FAIL reject %0d pulses: writes=%0d errs=%0d dones=%0d required 0 1 0",
                         i, wq.size(), err_q.size(), done_q.size());
            end
        end
    endtask

    task automatic test_transparency();
        int card;
        card = int'($urandom_range(NUM_CARDS - 1, 0));
        fill_card(card, 2);
        run_blit("transparency", card, int'($urandom_range(240, 0)), int'($urandom_range(220, 0)));
        n_chk++;
        if (wq.size() != SPRITE_WORDS / 2) begin
            n_fail++;
            $display("FAIL transparency count: got %0d required %0d", wq.size(), SPRITE_WORDS / 2);
        end
    endtask

    task automatic test_blit_random();
        int card;
        for (int n = 0; n < 4; n++) begin
            card = int'($urandom_range(NUM_CARDS - 1, 0));
            fill_card(card, 0);
            run_blit("blit_random", card, int'($urandom_range(240, 0)), int'($urandom_range(220, 0)));
        end
    endtask

    task automatic test_clear();
        int t, k, dc;
        wq.delete(); done_q.delete(); err_q.delete();
        send_cmd(OP_CLEAR, 0, 0, 0, 2, t);
        k = 0;
        while (done_q.size() == 0 && k < 62000) begin
            @(negedge clock);
            k++;
        end
        repeat (2) @(negedge clock);
        dc = (done_q.size() > 0) ? done_q[0] : -1;
        n_chk++;
        if (done_q.size() != 1 || dc != t + 61442 || err_q.size() != 0) begin
            n_fail++;
            $display("FAIL clear done: %0d pulses at %0d (errs %0d), required 1 at %0d",
                     done_q.size(), dc, err_q.size(), t + 61442);
        end
        n_chk++;
        if (wq.size() != FB_WORDS) begin
            n_fail++;
            $display("FAIL clear count: got %0d required %0d", wq.size(), FB_WORDS);
        end
        for (int i = 0; i < FB_WORDS && i < wq.size(); i++) begin
            n_chk++;
            if (wq[i].c != t + 2 + i || wq[i].a != i || wq[i].d != 2) begin
                n_fail++;
                $display("FAIL clear write %0d: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=2",
                         i, wq[i].c, wq[i].a, wq[i].d, t + 2 + i, i);
                break;
            end
        end
    endtask

    task automatic test_reset_mid_blit();
        int t, card, x, y;
        card = int'($urandom_range(NUM_CARDS - 1, 0));
        x    = int'($urandom_range(240, 0));
        y    = int'($urandom_range(220, 0));
        fill_card(card, 3);
        wq.delete(); done_q.delete(); err_q.delete();
        send_cmd(OP_BLIT, card, x, y, 0, t);
        build_exp(card, x, y, t, 100);
        while (cyc < t + 102) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        n_chk++;
        if (bus.fb_we !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset mid-blit: we=%b ready=%b required 0 0", bus.fb_we, bus.cmd_ready);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (30) @(negedge clock);
        n_chk++;
        if (done_q.size() != 0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 ||
            bus.rom_addr !== '0 || bus.fb_addr !== '0) begin
            n_fail++;
            $display("FAIL after abort: dones=%0d busy=%b ready=%b rom_addr=%0d fb_addr=%0d required 0 0 1 0 0",
                     done_q.size(), bus.busy, bus.cmd_ready, bus.rom_addr, bus.fb_addr);
        end
        n_chk++;
        if (wq.size() != expq.size()) begin
            n_fail++;
            $display("FAIL abort write count: got %0d required %0d", wq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < wq.size(); i++) begin
            n_chk++;
            if (wq[i].c != expq[i].c || wq[i].a != expq[i].a || wq[i].d != expq[i].d) begin
                n_fail++;
                $display("FAIL abort write %0d: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                         i, wq[i].c, wq[i].a, wq[i].d, expq[i].c, expq[i].a, expq[i].d);
                break;
            end
        end
        fill_card(card, 0);
        run_blit("blit_after_reset", card, x, y);
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_BLIT;
        bus.cmd_card  = '0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_color = '0;
        for (int i = 0; i < ROM_WORDS; i++) rom[i] = 3'b000;

        test_reset();
        test_blit_origin();
        test_blit_corner();
        test_reject();
        test_transparency();
        test_blit_random();
        test_clear();
        test_reset_mid_blit();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
